de_scoreboard_rf: RTL and testbench

DE_SCOREBOARD_RF -- requirements
Module: de_scoreboard_rf

---
 rtl/de_scoreboard_rf_pkg.sv | 16 +
 rtl/de_scoreboard_rf_ctr.sv | 43 ++++
 rtl/de_scoreboard_rf.sv | 90 +++++++++
 tb/tb_de_scoreboard_rf.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de_scoreboard_rf_pkg.sv
// Shared pipeline defines for the decode scoreboard / register file.
// Data width default, register-ID width derivation and register-ID type.
package de_scoreboard_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int rw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RW_DEF = rw_of(NREGS_DEF);

  typedef logic [RW_DEF-1:0] reg_id_t;

endpackage

// File: rtl/de_scoreboard_rf_ctr.sv
// Per-register pending-writer counter.
// Net +inc -wb -kill per cycle, saturating, with sticky error.
module sb_pending_ctr #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec_wb,
  input  logic            dec_kill,
  output logic [CNTW-1:0] cnt,
  output logic            err
);

  localparam int SW = CNTW + 2;

  logic [SW-1:0]   sum;
  logic [CNTW-1:0] nxt;
  logic            unf;
  logic            ovf;

  // Signed sum in a 2-bit wider field; MSB set means below zero.
  always_comb begin
    sum = SW'(cnt) + SW'(inc) - SW'(dec_wb) - SW'(dec_kill);
    unf = sum[SW-1];
    ovf = !unf && sum[CNTW];
    nxt = sum[CNTW-1:0];
    if (unf) nxt = '0;
    if (ovf) nxt = '1;
  end

  // Counter state and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= nxt;
      if (unf || ovf) err <= 1'b1;
    end
  end

endmodule

// File: rtl/de_scoreboard_rf.sv
// Decode-stage register file with pending-write scoreboard.
// Combinational reads with optional WB bypass; RAW/WAW stall.
module de_scoreboard_rf
  import de_scoreboard_rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NRD       = 2,
  parameter int CNTW      = 2,
  parameter int WB_BYPASS = 1,
  localparam int RW       = rw_of(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [NRD*RW-1:0] rs_addr,
  input  logic [NRD-1:0]    rs_used,
  input  logic              issue_wr,
  input  logic [RW-1:0]     issue_rd,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              kill_valid,
  input  logic [RW-1:0]     kill_rd,
  output logic [NRD*XLEN-1:0] rdata,
  output logic              stall,
  output logic              sb_err
);

  localparam logic [CNTW-1:0] PMAX = '1;

  logic [XLEN-1:0] regs [NREGS];
  logic [CNTW-1:0] pend [NREGS];
  logic [NREGS-1:0] err_vec;
  logic [NRD-1:0]   raw;
  logic             wb_ok;
  logic             waw;
  logic             accept;

  assign wb_ok = wb_valid && (wb_rd != '0);

  // Per-port read mux and RAW hazard detection.
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [RW-1:0] a;
    logic          hit;
    assign a   = rs_addr[i*RW +: RW];
    assign hit = (WB_BYPASS != 0) && wb_ok && (wb_rd == a);
    assign rdata[i*XLEN +: XLEN] =
      (reset || a == '0) ? '0 :
      hit ? wb_data : regs[a];
    assign raw[i] = rs_used[i] && (pend[a] != '0) &&
      !(hit && pend[a] == CNTW'(1));
  end

  // Writer cap: full counter blocks issue unless retired this cycle.
  assign waw = issue_wr && (issue_rd != '0) &&
    (pend[issue_rd] == PMAX) &&
    !((wb_valid && wb_rd == issue_rd) ||
      (kill_valid && kill_rd == issue_rd));

  assign stall  = !reset && issue_valid && ((|raw) || waw);
  assign accept = issue_valid && !stall && issue_wr &&
    (issue_rd != '0);
  assign sb_err = |err_vec;

  assign pend[0]    = '0;
  assign err_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    sb_pending_ctr #(.CNTW(CNTW)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (accept && issue_rd == RW'(r)),
      .dec_wb   (wb_valid && wb_rd == RW'(r)),
      .dec_kill (kill_valid && kill_rd == RW'(r)),
      .cnt      (pend[r]),
      .err      (err_vec[r])
    );
  end

  // Synchronous register write; x0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wb_ok) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_de_scoreboard_rf.sv
// Testbench for de_scoreboard_rf: bypass and no-bypass instances
// driven in parallel, directed scenarios plus randomized model check.
module tb_de_scoreboard_rf;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int CNTW = 2;
  localparam int RW = 5;
  localparam int MAXP = 3;

  logic clk = 0;
  logic reset;
  logic issue_valid;
  logic [NRD*RW-1:0] rs_addr;
  logic [NRD-1:0] rs_used;
  logic issue_wr;
  logic [RW-1:0] issue_rd;
  logic wb_valid;
  logic [RW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic kill_valid;
  logic [RW-1:0] kill_rd;
  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic stall_b, stall_n, err_b, err_n;

  int n_cmp = 0;
  int n_bad = 0;

  // model: index 0 = bypass instance, 1 = no-bypass instance
  int m_pend [2][NREGS];
  logic [XLEN-1:0] m_regs [NREGS];
  bit m_err [2];

  always #5 clk = ~clk;

  de_scoreboard_rf #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
    .CNTW(CNTW), .WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rs_used(rs_used), .issue_wr(issue_wr),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .rdata(rdata_b), .stall(stall_b), .sb_err(err_b));

  de_scoreboard_rf #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
    .CNTW(CNTW), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rs_used(rs_used), .issue_wr(issue_wr),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .rdata(rdata_n), .stall(stall_n), .sb_err(err_n));

  function automatic int port_addr(int i);
    return int'(rs_addr[i*RW +: RW]);
  endfunction

  function automatic logic [XLEN-1:0] m_rdata(int b, int i);
    int a = port_addr(i);
    if (reset || a == 0) return '0;
    if (b == 0 && wb_valid && int'(wb_rd) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_stall(int b);
    int rd = int'(issue_rd);
    bit retire;
    if (reset || !issue_valid) return 0;
    for (int i = 0; i < NRD; i++) begin
      int a = port_addr(i);
      if (rs_used[i] && m_pend[b][a] > 0) begin
        if (!(b == 0 && m_pend[b][a] == 1 && wb_valid &&
              int'(wb_rd) == a))
          return 1;
      end
    end
    retire = (wb_valid && wb_rd == issue_rd) ||
             (kill_valid && kill_rd == issue_rd);
    if (issue_wr && rd != 0 && m_pend[b][rd] == MAXP && !retire)
      return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[0][r] = 0;
      m_pend[1][r] = 0;
    end
    m_err[0] = 0;
    m_err[1] = 0;
  endtask

  task automatic m_step();
    bit acc [2];
    for (int b = 0; b < 2; b++)
      acc[b] = issue_valid && !m_stall(b) && issue_wr && issue_rd != 0;
    for (int b = 0; b < 2; b++)
      for (int r = 1; r < NREGS; r++) begin
        int n = m_pend[b][r];
        if (acc[b] && int'(issue_rd) == r) n++;
        if (wb_valid && int'(wb_rd) == r) n--;
        if (kill_valid && int'(kill_rd) == r) n--;
        if (n < 0) begin n = 0; m_err[b] = 1; end
        if (n > MAXP) begin n = MAXP; m_err[b] = 1; end
        m_pend[b][r] = n;
      end
    if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
  endtask

  task automatic idle();
    issue_valid = 0; rs_addr = '0; rs_used = '0;
    issue_wr = 0; issue_rd = '0; wb_valid = 0; wb_rd = '0;
    wb_data = '0; kill_valid = 0; kill_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    m_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd5;
    rs_addr = {5'd9, 5'd6}; rs_used = 2'b11;
    wb_valid = 1; wb_rd = 5'd6; wb_data = 32'hdead_beef;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || stall_n !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stall: got %b/%b want 0/0", stall_b, stall_n);
    end
    n_cmp++;
    if (rdata_b !== '0 || rdata_n !== '0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h/%h want 0", rdata_b, rdata_n);
    end
    n_cmp++;
    if (err_b !== 1'b0 || err_n !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b/%b want 0/0", err_b, err_n);
    end
    @(negedge clk);
    reset = 0;
    wb_valid = 0;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || rdata_b !== '0) begin
      n_bad++;
      $display("FAIL post_reset: got stall %b data %h want 0/0",
        stall_b, rdata_b);
    end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd5;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || stall_n !== 1'b0) begin
      n_bad++;
      $display("FAIL byp_issue: got %b/%b want 0/0", stall_b, stall_n);
    end
    tick();
    issue_wr = 0; issue_rd = '0;
    rs_addr = {5'd0, 5'd5}; rs_used = 2'b01;
    #1;
    n_cmp++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1) begin
      n_bad++;
      $display("FAIL byp_raw: got %b/%b want 1/1", stall_b, stall_n);
    end
    tick();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h1234;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || rdata_b[31:0] !== 32'h1234) begin
      n_bad++;
      $display("FAIL byp_fwd: got stall %b data %h want 0/1234",
        stall_b, rdata_b[31:0]);
    end
    n_cmp++;
    if (stall_n !== 1'b1) begin
      n_bad++;
      $display("FAIL nobyp_hold: got %b want 1", stall_n);
    end
    tick();
    wb_valid = 0; wb_rd = '0; wb_data = '0;
    #1;
    n_cmp++;
    if (stall_n !== 1'b0 || rdata_n[31:0] !== 32'h1234) begin
      n_bad++;
      $display("FAIL nobyp_rel: got stall %b data %h want 0/1234",
        stall_n, rdata_n[31:0]);
    end
    tick();
    idle();
  endtask

  task automatic test_waw_cap();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (stall_b !== 1'b0) begin
        n_bad++;
        $display("FAIL waw_accept%0d: got %b want 0", k, stall_b);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1) begin
      n_bad++;
      $display("FAIL waw_cap: got %b/%b want 1/1", stall_b, stall_n);
    end
    tick();
    kill_valid = 1; kill_rd = 5'd7;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0) begin
      n_bad++;
      $display("FAIL waw_kill_rel: got %b want 0", stall_b);
    end
    tick();
    kill_valid = 0;
    #1;
    n_cmp++;
    if (stall_b !== 1'b1) begin
      n_bad++;
      $display("FAIL waw_refull: got %b want 1", stall_b);
    end
    n_cmp++;
    if (err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL waw_err: got %b want 0", err_b);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd3;
    tick();
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'haa;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0) begin
      n_bad++;
      $display("FAIL same_issue: got %b want 0", stall_b);
    end
    tick();
    idle();
    issue_valid = 1; rs_addr = {5'd3, 5'd0}; rs_used = 2'b10;
    #1;
    n_cmp++;
    if (stall_b !== 1'b1 || stall_n !== 1'b1) begin
      n_bad++;
      $display("FAIL same_pend: got %b/%b want 1/1", stall_b, stall_n);
    end
    n_cmp++;
    if (rdata_b[63:32] !== 32'haa) begin
      n_bad++;
      $display("FAIL same_data: got %h want aa", rdata_b[63:32]);
    end
    idle();
  endtask

  task automatic test_err();
    do_reset();
    kill_valid = 1; kill_rd = 5'd9;
    #1;
    n_cmp++;
    if (err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pre: got %b want 0", err_b);
    end
    tick();
    idle();
    issue_valid = 1; rs_addr = {5'd0, 5'd9}; rs_used = 2'b01;
    #1;
    n_cmp++;
    if (err_b !== 1'b1 || err_n !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got %b/%b want 1/1", err_b, err_n);
    end
    n_cmp++;
    if (stall_b !== 1'b0) begin
      n_bad++;
      $display("FAIL err_sat0: got %b want 0", stall_b);
    end
    tick();
    tick();
    #1;
    n_cmp++;
    if (err_b !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", err_b);
    end
    reset = 1;
    m_reset();
    #1;
    n_cmp++;
    if (err_b !== 1'b0 || err_n !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: got %b/%b want 0/0", err_b, err_n);
    end
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  task automatic test_x0_reset();
    do_reset();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd0;
    tick();
    issue_wr = 0;
    rs_addr = '0; rs_used = 2'b11;
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h77;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || rdata_b !== '0) begin
      n_bad++;
      $display("FAIL x0_read: got stall %b data %h want 0/0",
        stall_b, rdata_b);
    end
    tick();
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd4;
    tick();
    tick();
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h55;
    tick();
    #2;
    reset = 1;
    m_reset();
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h66;
    issue_wr = 0; rs_addr = {5'd4, 5'd4}; rs_used = 2'b11;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || rdata_b !== '0 || rdata_n !== '0) begin
      n_bad++;
      $display("FAIL midrst_in: got stall %b data %h want 0/0",
        stall_b, rdata_b);
    end
    @(negedge clk);
    reset = 0;
    wb_valid = 0;
    #1;
    n_cmp++;
    if (stall_b !== 1'b0 || stall_n !== 1'b0 || rdata_b !== '0) begin
      n_bad++;
      $display("FAIL midrst_out: got stall %b/%b data %h want 0",
        stall_b, stall_n, rdata_b);
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int cand [$];
      for (int r = 1; r < 8; r++)
        if (m_pend[0][r] > 0 && m_pend[1][r] > 0) cand.push_back(r);
      idle();
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr = $urandom_range(0, 1);
      issue_rd = RW'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++)
        rs_addr[i*RW +: RW] = RW'($urandom_range(0, 7));
      rs_used = NRD'($urandom);
      wb_data = $urandom;
      if (cand.size() > 0 && $urandom_range(0, 9) < 5) begin
        wb_valid = 1;
        wb_rd = RW'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      if (cand.size() > 0 && $urandom_range(0, 9) < 1) begin
        kill_valid = 1;
        kill_rd = RW'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      if ($urandom_range(0, 99) < 3) begin
        wb_valid = 1;
        wb_rd = RW'($urandom_range(0, 7));
      end
      if (c % 400 == 399) begin
        reset = 1;
        m_reset();
      end
      #1;
      n_cmp++;
      if (stall_b !== m_stall(0) || stall_n !== m_stall(1)) begin
        n_bad++;
        $display("FAIL rnd_stall c%0d: got %b/%b want %b/%b",
          c, stall_b, stall_n, m_stall(0), m_stall(1));
      end
      for (int i = 0; i < NRD; i++) begin
        n_cmp++;
        if (rdata_b[i*XLEN +: XLEN] !== m_rdata(0, i) ||
            rdata_n[i*XLEN +: XLEN] !== m_rdata(1, i)) begin
          n_bad++;
          $display("FAIL rnd_rdata c%0d p%0d: got %h/%h want %h/%h",
            c, i, rdata_b[i*XLEN +: XLEN], rdata_n[i*XLEN +: XLEN],
            m_rdata(0, i), m_rdata(1, i));
        end
      end
      n_cmp++;
      if (err_b !== m_err[0] || err_n !== m_err[1]) begin
        n_bad++;
        $display("FAIL rnd_err c%0d: got %b/%b want %b/%b",
          c, err_b, err_n, m_err[0], m_err[1]);
      end
      if (reset) begin
        @(negedge clk);
        reset = 0;
      end else begin
        tick();
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    m_reset();
    test_reset();
    test_bypass();
    test_waw_cap();
    test_same_cycle();
    test_err();
    test_x0_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
